// File: rtl/mem_pkg.sv
// Shared sizing constants, word/address types and the range helper
// used by the dual-port scratch RAM.
package mem_pkg;

   localparam int MEM_DATA_W = 16;
   localparam int MEM_ADDR_W = 5;
   localparam int MEM_DEPTH  = 32;

   typedef logic [MEM_DATA_W-1:0] mem_word_t;
   typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

   // An address is live only below the configured depth; anything above is a dead slot.
   function automatic logic in_range(input int addr, input int depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Storage for the scratch RAM: asynchronously cleared word array with a
// range-checked write port and a combinational read tap.
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] d_in,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rd_word
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Out-of-range writes match no word, so they are silently dropped.
   always_comb begin
      mem_d = mem_q;
      if (wr && in_range(int'(waddr), DEPTH)) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (waddr == ADDR_W'(i)) begin
               mem_d[i] = d_in;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Reading an address with no backing word yields zero.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr == ADDR_W'(i)) begin
            rd_word = mem_q[i];
         end
      end
   end

endmodule

// File: rtl/mem.sv
// Full-duplex scratch RAM: one write and one read port per clock, registered
// read data, write-first when both ports hit the same live word.
module mem
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] d_in,
   input  logic              rd,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] d_out
);

   logic [DATA_W-1:0] rd_word;
   logic              rd_hit;
   logic [DATA_W-1:0] d_out_d;
   logic [DATA_W-1:0] d_out_q;

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .waddr   (waddr),
      .d_in    (d_in),
      .raddr   (raddr),
      .rd_word (rd_word)
   );

   // The bypass only fires for a write that will actually land in the array.
   always_comb begin
      rd_hit  = wr && (waddr == raddr) && in_range(int'(waddr), DEPTH);
      d_out_d = d_out_q;
      if (rd) begin
         d_out_d = rd_hit ? d_in : rd_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_out_q <= '0;
      end else begin
         d_out_q <= d_out_d;
      end
   end

   assign d_out = d_out_q;

endmodule

// File: tb/tb_mem.sv
// Directed self-checking bench for the scratch RAM: reset, write/read, hold,
// write-first collision, full-duplex streaming and mid-operation reset.
module tb_mem;
   import mem_pkg::*;

   logic      clk;
   logic      rst;
   logic      wr;
   mem_addr_t waddr;
   mem_word_t d_in;
   logic      rd;
   mem_addr_t raddr;
   mem_word_t d_out;

   int n_compared;
   int n_mismatched;

   mem dut (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr),
      .waddr (waddr),
      .d_in  (d_in),
      .rd    (rd),
      .raddr (raddr),
      .d_out (d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle's inputs, then let a rising edge consume them.
   task automatic applyStimulus(input logic w, input mem_addr_t wa, input mem_word_t wd,
                                input logic r, input mem_addr_t ra);
      wr    = w;
      waddr = wa;
      d_in  = wd;
      rd    = r;
      raddr = ra;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input mem_word_t expected);
      n_compared++;
      assert (d_out === expected)
      else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, d_out, expected);
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rst   = 1'b0;
      wr    = 1'b0;
      waddr = '0;
      d_in  = '0;
      rd    = 1'b0;
      raddr = '0;

      // Reset held with enables active: nothing should move.
      applyStimulus(1'b1, 5'd3, 16'hDEAD, 1'b1, 5'd3);
      checkOutput("reset_held", 16'h0000);
      applyStimulus(1'b1, 5'd3, 16'hDEAD, 1'b1, 5'd3);
      rst = 1'b1;
      checkOutput("reset_release", 16'h0000);

      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd0);
      checkOutput("rst_rd0", 16'h0000);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd5);
      checkOutput("rst_rd5", 16'h0000);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd31);
      checkOutput("rst_rd31", 16'h0000);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd3);
      checkOutput("rst_rd3_ignored_write", 16'h0000);

      // Write then read.
      applyStimulus(1'b1, 5'd5, 16'hAABB, 1'b0, 5'd0);
      applyStimulus(1'b1, 5'd9, 16'hABCD, 1'b0, 5'd0);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd5);
      checkOutput("wr_rd5", 16'hAABB);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd9);
      checkOutput("wr_rd9", 16'hABCD);

      // Disabled write and output hold.
      applyStimulus(1'b0, 5'd10, 16'h2525, 1'b0, 5'd0);
      applyStimulus(1'b0, 5'd10, 16'h2525, 1'b1, 5'd10);
      checkOutput("nowr_rd10", 16'h0000);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd9);
      checkOutput("hold_zero", 16'h0000);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd9);
      checkOutput("rd9_again", 16'hABCD);

      // Same-address collision is write-first.
      applyStimulus(1'b1, 5'd7, 16'h1234, 1'b1, 5'd7);
      checkOutput("collide_bypass", 16'h1234);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0);
      checkOutput("hold_nonzero", 16'h1234);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd7);
      checkOutput("collide_stored", 16'h1234);

      // Independent ports: write/read different addresses in one cycle.
      applyStimulus(1'b1, 5'd20, 16'h5A5A, 1'b1, 5'd5);
      checkOutput("indep_rd5", 16'hAABB);

      // Full-duplex stream: read back the previous cycle's write.
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, mem_addr_t'(i), mem_word_t'(16'hF000 + i),
                       i > 0, mem_addr_t'(i - 1));
         if (i > 0) begin
            checkOutput($sformatf("duplex_%0d", i - 1), mem_word_t'(16'hF000 + i - 1));
         end
      end
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd31);
      checkOutput("duplex_31", 16'hF01F);

      // Asynchronous reset between edges with a write pending.
      wr    = 1'b1;
      waddr = 5'd12;
      d_in  = 16'h5555;
      rd    = 1'b1;
      raddr = 5'd31;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_clear", 16'h0000);
      @(posedge clk);
      #1;
      checkOutput("reset_hold_mid", 16'h0000);
      rst = 1'b1;
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd12);
      checkOutput("lost_write12", 16'h0000);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd5);
      checkOutput("post_rst_rd5", 16'h0000);
      applyStimulus(1'b1, 5'd5, 16'hC0DE, 1'b0, 5'd0);
      applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1, 5'd5);
      checkOutput("post_rst_wr5", 16'hC0DE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
